// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX engine among NREQ byte producers.
// Optional watchdog is compiled in when UART_SCHED_TIMEOUT_EN is defined.
module uart_tx_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      sched_busy,
  output logic                      timeout_err,
  input  logic                      err_clr
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned SW  = IDW + 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           sched_busy_q, sched_busy_d;

  logic           win_found_c;
  logic [IDW-1:0] win_idx_c;
  logic [SW-1:0]  scan_c;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]  wd_cnt_q, wd_cnt_d;
  logic           timeout_err_q, timeout_err_d;
  logic           wd_fire_c;
`endif

  // Winner: first valid requester at or above rr_ptr, wrapping past NREQ-1
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    scan_c      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_c = {1'b0, rr_ptr_q} + SW'(k);
      if (scan_c >= SW'(NREQ)) scan_c = scan_c - SW'(NREQ);
      if (!win_found_c && req_valid[scan_c[IDW-1:0]]) begin
        win_found_c = 1'b1;
        win_idx_c   = scan_c[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    req_ready  = '0;
`ifdef UART_SCHED_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = '0;
    wd_fire_c     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found_c) begin
          req_ready[win_idx_c] = rst_n;
          tx_data_d  = req_data[{win_idx_c, 3'b000} +: 8];
          grant_id_d = win_idx_c;
          rr_ptr_d   = (win_idx_c == IDW'(NREQ - 1)) ? '0 : win_idx_c + IDW'(1);
          tx_start_d = 1'b1;
          state_d    = S_LAUNCH;
        end
      end
      // A done pulse here means the engine finished before busy was seen
      S_LAUNCH: begin
        if (tx_done) begin
          tx_start_d = 1'b0;
          state_d    = S_IDLE;
        end else if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

`ifdef UART_SCHED_TIMEOUT_EN
    // Watchdog: counter is zero on entry to LAUNCH; a fire beats err_clr
    if (state_q != S_IDLE) begin
      wd_cnt_d  = wd_cnt_q + CW'(1);
      wd_fire_c = !tx_done && (wd_cnt_q == CW'(TIMEOUT_CYC - 1));
    end
    if (wd_fire_c) begin
      timeout_err_d = 1'b1;
      tx_start_d    = 1'b0;
      state_d       = S_IDLE;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end
`endif

    sched_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      sched_busy_q <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      sched_busy_q <= sched_busy_d;
`ifdef UART_SCHED_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign grant_id   = grant_id_q;
  assign sched_busy = sched_busy_q;

`ifdef UART_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  logic unused_c;
  assign unused_c    = err_clr ^ (TIMEOUT_CYC == 0);
  assign timeout_err = 1'b0;
`endif

endmodule
